// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg -- shared definitions for the PUF response controller.
//   RESP_W_DEF      : default number of response bits per challenge sequence
//   TIMEOUT_CYC_DEF : default RUN cycles allowed per bit before a forced decision
//   puf_state_e     : controller FSM states
//   puf_dec_t       : outcome of one RUN-cycle race evaluation
//   puf_decide()    : race arbitration between the two oscillator counters
// -----------------------------------------------------------------------------
package puf_pkg;

  localparam int RESP_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_CAPT = 3'd3,
    ST_DONE = 3'd4
  } puf_state_e;

  typedef struct packed {
    logic decided;  // the race for this bit is over
    logic bit_val;  // resulting response bit
    logic err;      // decision was forced (tie or timeout)
  } puf_dec_t;

  // A counter reaching its threshold always beats the timeout in the same
  // cycle; a simultaneous finish is a tie and yields a flagged 0.
  function automatic puf_dec_t puf_decide(input logic valid_a,
                                          input logic valid_b,
                                          input logic expired);
    puf_dec_t d;
    d = '0;
    if (valid_a && valid_b) begin
      d.decided = 1'b1;
      d.err     = 1'b1;
    end else if (valid_a) begin
      d.decided = 1'b1;
      d.bit_val = 1'b1;
    end else if (valid_b) begin
      d.decided = 1'b1;
    end else if (expired) begin
      d.decided = 1'b1;
      d.err     = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/puf_tmo_cntr.sv
// -----------------------------------------------------------------------------
// puf_tmo_cntr -- per-bit RUN timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (held during the CLR state)
//   en         : count enable (RUN state)
//   expired    : counter has reached TIMEOUT_CYC-1, i.e. this is the last
//                RUN cycle allowed for the current bit
// -----------------------------------------------------------------------------
module puf_tmo_cntr
  import puf_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  // The count is zero on the first RUN cycle, so expired rises on RUN
  // cycle TIMEOUT_CYC and the counter saturates there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/puf_resp_ctrl.sv
// -----------------------------------------------------------------------------
// puf_resp_ctrl -- sequences an arbiter-style ring-oscillator PUF: for each
// challenge index it clears two race counters, lets them run, records which
// one reached its threshold first, and assembles the bits LSB first.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_start       : start a sequence (honoured only when idle)
//   i_valid_a/b   : counter A/B reached its threshold
//   i_resp_ready  : consumer takes o_resp
//   o_cnt_en      : enable for both race counters
//   o_cnt_rst_n   : registered active-low clear for both race counters
//   o_chal        : current bit index / oscillator-pair select
//   o_busy        : sequence in progress (any state but IDLE)
//   o_resp_valid  : o_resp holds a finished response
//   o_resp        : assembled response
//   o_err         : sticky tie/timeout flag for the current sequence
// -----------------------------------------------------------------------------
module puf_resp_ctrl
  import puf_pkg::*;
#(
  parameter  int RESP_W      = RESP_W_DEF,
  parameter  int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int CHAL_W      = $clog2(RESP_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_valid_a,
  input  logic              i_valid_b,
  input  logic              i_resp_ready,
  output logic              o_cnt_en,
  output logic              o_cnt_rst_n,
  output logic [CHAL_W-1:0] o_chal,
  output logic              o_busy,
  output logic              o_resp_valid,
  output logic [RESP_W-1:0] o_resp,
  output logic              o_err
);

  localparam logic [CHAL_W-1:0] LAST_IDX = CHAL_W'(RESP_W - 1);

  puf_state_e        state_q, state_d;
  logic [CHAL_W-1:0] idx_q;
  logic              bit_q;
  logic [RESP_W-1:0] resp_q;
  logic              err_q;
  logic              tmo_expired;
  puf_dec_t          dec;

  puf_tmo_cntr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == ST_CLR),
    .en      (state_q == ST_RUN),
    .expired (tmo_expired)
  );

  // Only meaningful in RUN; valids seen in any other state are never used.
  assign dec = puf_decide(i_valid_a, i_valid_b, tmo_expired);

  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start)      state_d = ST_CLR;
      ST_CLR:                    state_d = ST_RUN;
      ST_RUN:  if (dec.decided)  state_d = ST_CAPT;
      ST_CAPT:                   state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_CLR;
      ST_DONE: if (i_resp_ready) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state and the counter clear is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt_en     <= 1'b0;
      o_cnt_rst_n  <= 1'b0;
      o_busy       <= 1'b0;
      o_resp_valid <= 1'b0;
      idx_q        <= '0;
      bit_q        <= 1'b0;
      // NOTE: the response register is a few flops, not a RAM, so it is reset like any other state.
      resp_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      o_cnt_en     <= (state_d == ST_RUN);
      o_cnt_rst_n  <= (state_d == ST_RUN) || (state_d == ST_CAPT);
      o_busy       <= (state_d != ST_IDLE);
      o_resp_valid <= (state_d == ST_DONE);

      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            idx_q  <= '0;
            resp_q <= '0;
            err_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (dec.decided) begin
            bit_q <= dec.bit_val;
            if (dec.err) err_q <= 1'b1;
          end
        end
        ST_CAPT: begin
          resp_q[idx_q] <= bit_q;
          // The index stays on the last bit through DONE; the next start clears it.
          if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_chal = idx_q;
  assign o_resp = resp_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puf_resp_ctrl -- bench for puf_resp_ctrl (RESP_W=8, TIMEOUT_CYC=64).
// Two behavioural race counters count RUN cycles and raise their valid once
// a per-bit threshold is reached; thresholds are given per sequence.
// -----------------------------------------------------------------------------
module tb_puf_resp_ctrl;

  localparam int RESP_W      = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int CHAL_W      = 3;
  localparam int NEVER       = 127;
  localparam int WAIT_MAX    = 3000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic              i_valid_a = 1'b0;
  logic              i_valid_b = 1'b0;
  logic              i_resp_ready = 1'b0;
  logic              o_cnt_en;
  logic              o_cnt_rst_n;
  logic [CHAL_W-1:0] o_chal;
  logic              o_busy;
  logic              o_resp_valid;
  logic [RESP_W-1:0] o_resp;
  logic              o_err;

  puf_resp_ctrl #(
    .RESP_W      (RESP_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_valid_a    (i_valid_a),
    .i_valid_b    (i_valid_b),
    .i_resp_ready (i_resp_ready),
    .o_cnt_en     (o_cnt_en),
    .o_cnt_rst_n  (o_cnt_rst_n),
    .o_chal       (o_chal),
    .o_busy       (o_busy),
    .o_resp_valid (o_resp_valid),
    .o_resp       (o_resp),
    .o_err        (o_err)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // RUN-cycle index (0 = first RUN cycle of the bit) at which each counter
  // reaches its threshold; NEVER means it does not finish.
  int set_a [RESP_W];
  int set_b [RESP_W];
  int run_cnt = 0;

  // Race counters: cleared while o_cnt_rst_n is low (their valids are then
  // scrambled to prove they are ignored), count while o_cnt_en is high.
  initial forever begin
    @(negedge clk);
    if (o_cnt_en) begin
      i_valid_a = (run_cnt >= set_a[o_chal]);
      i_valid_b = (run_cnt >= set_b[o_chal]);
      run_cnt++;
    end else if (!o_cnt_rst_n) begin
      run_cnt   = 0;
      i_valid_a = 1'($urandom_range(0, 1));
      i_valid_b = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/cnt_en"},     32'(o_cnt_en),     0);
    check({tag, "/cnt_rst_n"},  32'(o_cnt_rst_n),  0);
    check({tag, "/chal"},       32'(o_chal),       0);
    check({tag, "/busy"},       32'(o_busy),       0);
    check({tag, "/resp_valid"}, 32'(o_resp_valid), 0);
    check({tag, "/resp"},       32'(o_resp),       0);
    check({tag, "/err"},        32'(o_err),        0);
  endtask

  // Reference: each bit costs CLR + RUN + CAPT cycles. RUN ends on the first
  // threshold hit if that is within the TIMEOUT_CYC window, else at timeout.
  function automatic void ref_model(output logic [RESP_W-1:0] r, output logic e,
                                    output int cyc);
    r = '0; e = 1'b0; cyc = 0;
    for (int i = 0; i < RESP_W; i++) begin
      int t;
      t = (set_a[i] < set_b[i]) ? set_a[i] : set_b[i];
      if (t <= TIMEOUT_CYC - 1) begin
        cyc += t + 1 + 2;
        if (set_a[i] == set_b[i]) e = 1'b1;
        else                      r[i] = (set_a[i] < set_b[i]);
      end else begin
        cyc += TIMEOUT_CYC + 2;
        e = 1'b1;
      end
    end
  endfunction

  // One full sequence from IDLE back to IDLE, checking timing and results.
  task automatic run_seq(input string tag, input logic [RESP_W-1:0] er,
                         input logic ee, input int ecyc, input bit hold);
    int              edges, clr_cnt, bad;
    logic [RESP_W-1:0] chal_mask;
    logic [CHAL_W-1:0] prev_chal;
    logic [RESP_W-1:0] held_resp;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    check({tag, "/clr_outs"}, {o_busy, o_cnt_en, o_cnt_rst_n, o_err}, 32'b1000);
    check({tag, "/clr_chal"}, 32'(o_chal), 0);
    edges = 0; clr_cnt = 0; bad = 0; chal_mask = '0; prev_chal = '0;
    while (!o_resp_valid && edges < WAIT_MAX) begin
      if (o_busy && !o_cnt_rst_n)   clr_cnt++;
      if (o_cnt_en)                 chal_mask[o_chal] = 1'b1;
      if (o_cnt_en && !o_cnt_rst_n) bad++;
      if (o_chal < prev_chal)       bad++;
      if (!o_busy)                  bad++;
      prev_chal = o_chal;
      @(negedge clk);
      edges++;
    end
    check({tag, "/done_seen"}, 32'(o_resp_valid), 1);
    check({tag, "/cycles"},    32'(edges), 32'(ecyc));
    check({tag, "/resp"},      32'(o_resp), 32'(er));
    check({tag, "/err"},       32'(o_err),  32'(ee));
    check({tag, "/clr_pulses"}, 32'(clr_cnt), RESP_W);
    check({tag, "/chal_steps"}, 32'(chal_mask), 32'hFF);
    check({tag, "/seq_rules"}, 32'(bad), 0);
    check({tag, "/done_outs"}, {o_busy, o_cnt_en, o_cnt_rst_n}, 32'b100);
    if (hold) begin
      held_resp = o_resp;
      for (int k = 0; k < 10; k++) begin
        i_start = ~i_start;
        @(negedge clk);
        check({tag, "/hold"}, {o_resp_valid, o_busy, o_cnt_en, o_err, o_resp},
              {1'b1, 1'b1, 1'b0, ee, held_resp});
      end
      i_start = 1'b0;
    end
    i_resp_ready = 1'b1;
    @(negedge clk);
    i_resp_ready = 1'b0;
    check({tag, "/idle_after_ready"}, {o_resp_valid, o_busy}, 0);
    if (hold) begin
      @(negedge clk);
      check({tag, "/no_restart"}, {o_busy, o_cnt_rst_n}, 0);
    end
  endtask

  typedef struct packed {
    logic [RESP_W-1:0][6:0] da;
    logic [RESP_W-1:0][6:0] db;
    logic [RESP_W-1:0]      exp_resp;
    logic                   exp_err;
    logic [15:0]            exp_cyc;
  } vec_t;

  // Even/odd bits get their own thresholds; one optional bit is overridden.
  function automatic vec_t mk(input int a_ev, input int b_ev, input int a_od, input int b_od,
                              input int sp, input int a_sp, input int b_sp,
                              input logic [RESP_W-1:0] r, input logic e, input int cyc);
    vec_t v;
    for (int i = 0; i < RESP_W; i++) begin
      v.da[i] = 7'((i % 2 == 0) ? a_ev : a_od);
      v.db[i] = 7'((i % 2 == 0) ? b_ev : b_od);
      if (i == sp) begin
        v.da[i] = 7'(a_sp);
        v.db[i] = 7'(b_sp);
      end
    end
    v.exp_resp = r;
    v.exp_err  = e;
    v.exp_cyc  = 16'(cyc);
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < RESP_W; i++) begin
      set_a[i] = int'(v.da[i]);
      set_b[i] = int'(v.db[i]);
    end
  endtask

  vec_t vecs [6];

  initial begin
    logic [RESP_W-1:0] mr;
    logic              me;
    int                mc;
    int                waited;

    vecs[0] = mk(17, NEVER, 17, NEVER, -1, 0, 0, 8'hFF, 1'b0, 160);  // A at RUN+17
    vecs[1] = mk(3, 9, 9, 3, -1, 0, 0,           8'h55, 1'b0, 48);   // alternate
    vecs[2] = mk(2, NEVER, 2, NEVER, 3, 5, 5,    8'hF7, 1'b1, 43);   // tie on bit 3
    vecs[3] = mk(0, NEVER, 0, NEVER, 0, NEVER, NEVER, 8'hFE, 1'b1, 87); // timeout bit 0
    vecs[4] = mk(63, NEVER, 63, NEVER, -1, 0, 0, 8'hFF, 1'b0, 528);  // valid beats timeout
    vecs[5] = mk(NEVER, 62, NEVER, 62, -1, 0, 0, 8'h00, 1'b0, 520);  // B just in time
    for (int i = 0; i < RESP_W; i++) begin
      set_a[i] = NEVER;
      set_b[i] = NEVER;
    end

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v]);
      run_seq($sformatf("vec%0d", v), vecs[v].exp_resp, vecs[v].exp_err,
              int'(vecs[v].exp_cyc), 1'b0);
    end

    // DONE held with i_start toggling, then release.
    load_vec(vecs[1]);
    run_seq("hold", 8'h55, 1'b0, 48, 1'b1);

    // Asynchronous reset during RUN of bit 4, then a clean sequence.
    load_vec(vecs[0]);
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    waited = 0;
    while (!(o_cnt_en && o_chal == 3'd4) && waited < WAIT_MAX) begin
      @(negedge clk);
      waited++;
    end
    check("midrst/reach_bit4", {o_cnt_en, o_chal}, {1'b1, 3'd4});
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst/async");
    @(negedge clk);
    check_reset_vals("midrst/held");
    rst_n = 1'b1;
    run_seq("after_rst", 8'hFF, 1'b0, 160, 1'b0);

    // Randomized sequences against the reference model.
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < RESP_W; i++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
          set_a[i] = NEVER; set_b[i] = NEVER;
        end else if (r == 1) begin
          set_a[i] = int'($urandom_range(0, 20)); set_b[i] = set_a[i];
        end else if (r == 2) begin
          set_a[i] = int'($urandom_range(60, 70)); set_b[i] = NEVER;
        end else begin
          set_a[i] = int'($urandom_range(0, 20)); set_b[i] = int'($urandom_range(0, 20));
        end
      end
      ref_model(mr, me, mc);
      run_seq($sformatf("rand%0d", s), mr, me, mc, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/puf_resp_ctrl.md
PUF_RESP_CTRL -- requirements
Module: puf_resp_ctrl

Interface
REQ-001 Parameter RESP_W, default 8, number of response bits per challenge sequence (2..32).
REQ-002 Parameter TIMEOUT_CYC, default 64, maximum RUN cycles per bit before forced decision.
REQ-003 Derived constant CHAL_W = $clog2(RESP_W), width of the bit index / challenge select.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 i_start  in  1  start request, sampled only in IDLE.
REQ-007 i_valid_a  in  1  o_valid from puf_cntr instance A (oscillator A reached CNT_SET).
REQ-008 i_valid_b  in  1  o_valid from puf_cntr instance B.
REQ-009 i_resp_ready  in  1  consumer accepts o_resp.
REQ-010 o_cnt_en  out  1  drives i_en of both counters.
REQ-011 o_cnt_rst_n  out  1  registered, glitch-free active-low clear driving rst_n of both counters.
REQ-012 o_chal  out  CHAL_W  current bit index, selects the oscillator pair.
REQ-013 o_busy  out  1  high in every state except IDLE.
REQ-014 o_resp_valid  out  1  response available.
REQ-015 o_resp  out  RESP_W  assembled response.
REQ-016 o_err  out  1  sticky; set by a tie or a timeout in the current sequence.

Function
REQ-017 FSM states SHALL be IDLE, CLR, RUN, CAPT, DONE; all outputs registered.
REQ-018 IDLE: o_cnt_en=0, o_cnt_rst_n=0; i_start=1 -> CLR, with index, o_resp and o_err cleared on the same edge.
REQ-019 CLR: exactly one cycle; o_cnt_rst_n=0, o_cnt_en=0, timeout counter cleared; -> RUN.
REQ-020 RUN: o_cnt_rst_n=1, o_cnt_en=1; the timeout counter increments every cycle.
REQ-021 RUN decision: i_valid_a=1 and i_valid_b=0 -> bit=1; i_valid_b=1 and i_valid_a=0 -> bit=0; -> CAPT.
REQ-022 Both valids high in the same cycle: bit=0, o_err set, -> CAPT.
REQ-023 Timeout counter reaches TIMEOUT_CYC-1 with no valid: bit=0, o_err set, -> CAPT; valid in the same cycle takes priority over timeout.
REQ-024 CAPT: one cycle; o_cnt_en=0, o_cnt_rst_n=1; o_resp[index] <= bit (LSB first).
REQ-025 CAPT with index==RESP_W-1 -> DONE; otherwise index+1 -> CLR.
REQ-026 o_chal SHALL equal the index and stay constant from CLR through CAPT of that bit.
REQ-027 DONE: o_resp_valid=1, o_cnt_rst_n=0; o_resp and o_err held stable until i_resp_ready=1, then -> IDLE and o_resp_valid=0 next cycle.
REQ-028 i_start outside IDLE SHALL be ignored; i_valid_a/b outside RUN SHALL be ignored.
REQ-029 Per-bit latency SHALL be 1 (CLR) + N (RUN, 1..TIMEOUT_CYC) + 1 (CAPT) cycles.
REQ-030 o_err SHALL remain set until the next accepted i_start.

Reset
REQ-031 rst_n low SHALL force IDLE immediately, at any point including mid-sequence.
REQ-032 Reset values: o_cnt_en=0, o_cnt_rst_n=0, o_chal=0, o_busy=0, o_resp_valid=0, o_resp=0, o_err=0, index=0, timeout counter=0.

Structure
REQ-033 The state encodings and the RESP_W/TIMEOUT_CYC defaults SHALL live in the shared package puf_pkg.
REQ-034 The timeout counter SHALL be the sub-module puf_tmo_cntr, with ports clr, en and expired.
REQ-035 The FSM, the index register and the response register SHALL stay in puf_resp_ctrl.

Verification
REQ-036 i_start pulse; i_valid_a asserted 17 cycles after RUN entry for every bit -> o_resp=8'hFF, o_err=0, o_resp_valid after 8*(1+18+1) cycles.
REQ-037 Alternate A-first / B-first per bit -> o_resp=8'h55, o_err=0; o_chal steps 0..7; o_cnt_rst_n low exactly one cycle between bits.
REQ-038 Both valids high in the same cycle on bit 3, A-first elsewhere -> o_resp=8'hF7, o_err=1.
REQ-039 No valid on bit 0, A-first elsewhere -> RUN for bit 0 lasts exactly 64 cycles, o_resp=8'hFE, o_err=1.
REQ-040 Hold i_resp_ready=0 for 10 cycles in DONE with i_start toggling -> o_resp stable, no restart; i_resp_ready=1 -> IDLE next cycle.
REQ-041 rst_n pulsed low during RUN of bit 4 -> all outputs at reset values asynchronously; a new i_start runs a full clean sequence.
